// File: rtl/bus_demux_2ch_4bit.sv
// Rebuilds the ch0/ch1 words of a time-shared, select-tagged bus and commits each pair atomically.
// Optional ch0->ch1 idle timeout is built when BUS_DEMUX_TIMEOUT_EN is defined.
module bus_demux_2ch_4bit #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic             pair_valid,
  output logic             seq_err,
  output logic [7:0]       pair_cnt
);

  typedef enum logic {WAIT0, WAIT1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shadow0_q;
  logic [WIDTH-1:0] ch0_q;
  logic [WIDTH-1:0] ch1_q;
  logic             pair_valid_q;
  logic             seq_err_q;
  logic [7:0]       pair_cnt_q;
  logic [7:0]       pair_cnt_d;
  logic             tmo_hit;

  always_comb pair_cnt_d = pair_cnt_q + 8'd1;

`ifdef BUS_DEMUX_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic [7:0] tmo_cnt_d;

  // A valid word at the would-be timeout edge wins, so only idle WAIT1 cycles can fire.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 8'd1;
    tmo_hit   = (state_q == WAIT1) && !in_valid && (tmo_cnt_d == 8'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (!reset_n || state_q != WAIT1 || in_valid) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // TIMEOUT only matters when the timer is built.
  always_comb tmo_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= WAIT0;
      shadow0_q    <= '0;
      ch0_q        <= '0;
      ch1_q        <= '0;
      pair_valid_q <= 1'b0;
      seq_err_q    <= 1'b0;
      pair_cnt_q   <= '0;
    end else begin
      pair_valid_q <= 1'b0;
      // Clear first so that any error set below in the same cycle takes priority.
      if (clear_err) seq_err_q <= 1'b0;
      case (state_q)
        WAIT0: begin
          if (in_valid) begin
            if (!in_sel) begin
              shadow0_q <= in_data;
              state_q   <= WAIT1;
            end else begin
              seq_err_q <= 1'b1;
            end
          end
        end
        WAIT1: begin
          if (in_valid) begin
            if (in_sel) begin
              ch0_q        <= shadow0_q;
              ch1_q        <= in_data;
              pair_cnt_q   <= pair_cnt_d;
              pair_valid_q <= 1'b1;
              state_q      <= WAIT0;
            end else begin
              shadow0_q <= in_data;
              seq_err_q <= 1'b1;
            end
          end else if (tmo_hit) begin
            shadow0_q <= '0;
            seq_err_q <= 1'b1;
            state_q   <= WAIT0;
          end
        end
        default: state_q <= WAIT0;
      endcase
    end
  end

  assign ch0_data   = ch0_q;
  assign ch1_data   = ch1_q;
  assign pair_valid = pair_valid_q;
  assign seq_err    = seq_err_q;
  assign pair_cnt   = pair_cnt_q;

endmodule

// File: tb/tb_bus_demux_2ch_4bit.sv
// Scoreboard bench for bus_demux_2ch_4bit: stimulus pushes expected pairs, a monitor pops them on pair_valid.
// The timeout scenario follows BUS_DEMUX_TIMEOUT_EN the same way the design does.
module tb_bus_demux_2ch_4bit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_sel;
  logic [3:0] in_data;
  logic       clear_err;
  logic [3:0] ch0_data;
  logic [3:0] ch1_data;
  logic       pair_valid;
  logic       seq_err;
  logic [7:0] pair_cnt;

  typedef struct {
    logic [3:0] ch0;
    logic [3:0] ch1;
    logic [7:0] cnt;
  } pair_t;

  pair_t      sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pulses   = 0;
  logic       prev_pv  = 1'b0;
  logic [7:0] exp_cnt  = 8'd0;
  bit         done     = 1'b0;

  bus_demux_2ch_4bit #(.WIDTH(4), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .clear_err (clear_err),
    .ch0_data  (ch0_data),
    .ch1_data  (ch1_data),
    .pair_valid(pair_valid),
    .seq_err   (seq_err),
    .pair_cnt  (pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pair_valid pulse must match the oldest expected pair and last one cycle.
  always @(negedge clk) begin
    if (!done) begin
      if (pair_valid === 1'b1) begin
        pulses++;
        n_checks++;
        if (prev_pv) begin
          n_fail++;
          $display("FAIL pv_width: pair_valid high two cycles in a row");
        end
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL pv_unexpected: pulse with ch0=0x%0h ch1=0x%0h cnt=%0d, none expected",
                   ch0_data, ch1_data, pair_cnt);
        end else begin
          pair_t e;
          e = sb.pop_front();
          if (ch0_data !== e.ch0 || ch1_data !== e.ch1 || pair_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL pair: got %0h/%0h cnt=%0d expected %0h/%0h cnt=%0d",
                     ch0_data, ch1_data, pair_cnt, e.ch0, e.ch1, e.cnt);
          end
        end
      end
      prev_pv = (pair_valid === 1'b1);
    end
  end

  task automatic send(input logic v, input logic sel, input logic [3:0] d, input logic clr);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    clear_err = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sel    = 1'b0;
    in_data   = 4'h0;
    clear_err = 1'b0;
  endtask

  task automatic commit(input logic [3:0] d0, input logic [3:0] d1);
    pair_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.ch0 = d0;
    e.ch1 = d1;
    e.cnt = exp_cnt;
    sb.push_back(e);
    send(1'b1, 1'b1, d1, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    send(1'b0, 1'b0, 4'h0, 1'b0);
    reset_n = 1'b1;
    exp_cnt = 8'd0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 1'b0;
    in_data   = 4'h0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ch0", ch0_data, 0);
    check("rst_ch1", ch1_data, 0);
    check("rst_pv", pair_valid, 0);
    check("rst_err", seq_err, 0);
    check("rst_cnt", pair_cnt, 0);
    reset_n = 1'b1;

    // Reset mid-pair drops shadow0; the following ch1 is an ordering error.
    send(1'b1, 1'b0, 4'h3, 1'b0);
    reset_n = 1'b0;
    send(1'b1, 1'b1, 4'hF, 1'b0);
    reset_n = 1'b1;
    send(1'b1, 1'b1, 4'h7, 1'b0);
    check("midrst_err", seq_err, 1);
    check("midrst_ch0", ch0_data, 0);
    check("midrst_ch1", ch1_data, 0);
    check("midrst_cnt", pair_cnt, 0);
    send(1'b0, 1'b0, 4'h0, 1'b1);
    check("midrst_clr", seq_err, 0);

    // Basic commit.
    send(1'b1, 1'b0, 4'h5, 1'b0);
    commit(4'h5, 4'h9);
    check("basic_pv", pair_valid, 1);
    check("basic_err", seq_err, 0);
    send(1'b0, 1'b0, 4'h0, 1'b0);
    check("basic_pv_low", pair_valid, 0);
    check("basic_ch0_hold", ch0_data, 5);

    // Ordering errors: stray ch1, then repeated ch0 overwrites the shadow.
    send(1'b1, 1'b1, 4'hA, 1'b0);
    check("ord_err", seq_err, 1);
    check("ord_ch0", ch0_data, 5);
    check("ord_ch1", ch1_data, 9);
    send(1'b1, 1'b0, 4'h1, 1'b0);
    send(1'b1, 1'b0, 4'h2, 1'b0);
    check("ord_partial_ch0", ch0_data, 5);
    commit(4'h2, 4'h4);
    check("ord_err_sticky", seq_err, 1);
    send(1'b0, 1'b0, 4'h0, 1'b1);
    check("ord_clr", seq_err, 0);

    // Error and clear in the same cycle: set wins.
    send(1'b1, 1'b1, 4'hC, 1'b1);
    check("simul_err", seq_err, 1);
    send(1'b0, 1'b0, 4'h0, 1'b1);
    check("simul_clr", seq_err, 0);

`ifdef BUS_DEMUX_TIMEOUT_EN
    send(1'b1, 1'b0, 4'h6, 1'b0);
    repeat (14) send(1'b0, 1'b0, 4'h0, 1'b0);
    check("tmo_err_before", seq_err, 0);
    send(1'b0, 1'b0, 4'h0, 1'b0);
    check("tmo_err", seq_err, 1);
    send(1'b1, 1'b1, 4'h8, 1'b0);
    check("tmo_ch1", ch1_data, 4);
    send(1'b0, 1'b0, 4'h0, 1'b1);
    send(1'b1, 1'b0, 4'h6, 1'b0);
    repeat (14) send(1'b0, 1'b0, 4'h0, 1'b0);
    commit(4'h6, 4'h8);
    check("tmo_edge_err", seq_err, 0);
`else
    send(1'b1, 1'b0, 4'h6, 1'b0);
    repeat (40) send(1'b0, 1'b0, 4'h0, 1'b0);
    check("notmo_err", seq_err, 0);
    commit(4'h6, 4'h8);
    check("notmo_err_after", seq_err, 0);
`endif
    check("pre_wrap_ch1", ch1_data, 8);

    // 256 back-to-back pairs from reset: counter wraps back to 0.
    do_reset();
    pulses = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      a = 4'(i);
      b = ~4'(i * 3);
      send(1'b1, 1'b0, a, 1'b0);
      commit(a, b);
    end
    send(1'b0, 1'b0, 4'h0, 1'b0);
    send(1'b0, 1'b0, 4'h0, 1'b0);
    check("wrap_pulses", pulses, 256);
    check("wrap_cnt", pair_cnt, 0);
    check("wrap_ch0", ch0_data, 4'hF);
    check("wrap_ch1", ch1_data, 4'h2);
    check("wrap_err", seq_err, 0);
    check("sb_empty", sb.size(), 0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
